// File: rtl/cards_regfile.sv
// Card register file: 18 value/state entries with combinational state look-up,
// plus a once-per-frame broadcaster that streams every slot and its grid position.
`ifndef CARDS_DEFS_SVH
`define CARDS_DEFS_SVH
`define CARD_MAX_NUM 18
`define CARD_MAX_NUM_SIZE 5
`define CARD_ADDRESS_SIZE 5
`define CARD_STATE_SIZE 2
`define CARD_DATA_SIZE 6
`define CARD_YX_POSITION_SIZE 24
`define CARD_NUM_EASY 8
`define CARD_NUM_NORMAL 12
`define CARD_NUM_HARD 18
`endif

// state  | meaning
// IDLE   | waiting for frame_start, stream outputs held at 0
// STREAM | presenting slot 1..18, one slot per cycle
module cards_regfile #(
    parameter int X0  = 88,
    parameter int Y0  = 76,
    parameter int GAP = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_start,
    input  logic [`CARD_MAX_NUM_SIZE-1:0]      num_of_cards_in,
    input  logic                               clear_all,
    input  logic                               wr_en,
    input  logic [`CARD_ADDRESS_SIZE-1:0]      wr_address,
    input  logic [`CARD_DATA_SIZE-1:0]         wr_data,
    input  logic [`CARD_ADDRESS_SIZE-1:0]      card_to_test_address,
    output logic [`CARD_STATE_SIZE-1:0]        card_test_state,
    output logic                               regfile_sync,
    output logic [`CARD_DATA_SIZE-1:0]         regfile_in,
    output logic [`CARD_YX_POSITION_SIZE-1:0]  yx_card_position,
    output logic [`CARD_MAX_NUM_SIZE-1:0]      num_of_cards,
    output logic                               busy,
    output logic                               broadcast_done
);
    localparam int DW = `CARD_DATA_SIZE;
    localparam int SW = `CARD_STATE_SIZE;
    localparam int AW = `CARD_ADDRESS_SIZE;
    localparam int NW = `CARD_MAX_NUM_SIZE;
    localparam int NUM = `CARD_MAX_NUM;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM);
    localparam logic [11:0] X_START = 12'(X0);
    localparam logic [11:0] Y_START = 12'(Y0);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t         state;
    logic [DW-1:0]  mem [0:NUM-1];
    logic [AW-1:0]  slot;
    logic [AW-1:0]  next_slot;
    logic [2:0]     col;
    logic [11:0]    x_pos;
    logic [11:0]    y_pos;
    logic [2:0]     cols;
    logic [11:0]    step_x;
    logic [11:0]    step_y;
    logic           wr_valid;
    logic [DW-1:0]  next_data;

    assign wr_valid         = wr_en && (wr_address != '0) && (wr_address <= LAST_ADDR);
    assign yx_card_position = {y_pos, x_pos};
    assign next_slot        = slot + AW'(1);

    always_comb begin
        card_test_state = '0;
        if ((card_to_test_address != '0) && (card_to_test_address <= LAST_ADDR))
            card_test_state = mem[card_to_test_address - AW'(1)][DW-1 -: SW];
    end

    // Grid geometry follows the difficulty latched at broadcast start.
    always_comb begin
        cols   = 3'd6;
        step_x = 12'(GAP);
        step_y = 12'(GAP);
        case (num_of_cards)
            NW'(`CARD_NUM_EASY): begin
                cols   = 3'd4;
                step_x = 12'(200 + GAP);
                step_y = 12'(300 + GAP);
            end
            NW'(`CARD_NUM_NORMAL): begin
                cols   = 3'd4;
                step_x = 12'(150 + GAP);
                step_y = 12'(200 + GAP);
            end
            NW'(`CARD_NUM_HARD): begin
                cols   = 3'd6;
                step_x = 12'(100 + GAP);
                step_y = 12'(150 + GAP);
            end
            default: ;
        endcase
    end

    always_comb begin
        next_data = '0;
        if ((next_slot <= AW'(num_of_cards)) && (next_slot <= LAST_ADDR))
            next_data = mem[next_slot - AW'(1)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) mem[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < NUM; i++) mem[i][DW-1 -: SW] <= '0;
        end else if (wr_valid) begin
            mem[wr_address - AW'(1)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            slot           <= '0;
            col            <= '0;
            x_pos          <= '0;
            y_pos          <= '0;
            regfile_sync   <= 1'b0;
            regfile_in     <= '0;
            num_of_cards   <= '0;
            busy           <= 1'b0;
            broadcast_done <= 1'b0;
        end else begin
            broadcast_done <= 1'b0;
            regfile_sync   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state        <= STREAM;
                        num_of_cards <= num_of_cards_in;
                        slot         <= AW'(1);
                        col          <= '0;
                        x_pos        <= X_START;
                        y_pos        <= Y_START;
                        regfile_sync <= 1'b1;
                        regfile_in   <= (num_of_cards_in != '0) ? mem[0] : '0;
                        busy         <= 1'b1;
                    end
                end
                STREAM: begin
                    if (slot == LAST_ADDR) begin
                        state          <= IDLE;
                        slot           <= '0;
                        col            <= '0;
                        x_pos          <= '0;
                        y_pos          <= '0;
                        regfile_in     <= '0;
                        busy           <= 1'b0;
                        broadcast_done <= 1'b1;
                    end else begin
                        slot       <= next_slot;
                        regfile_in <= next_data;
                        if (col == cols - 3'd1) begin
                            col   <= '0;
                            x_pos <= X_START;
                            y_pos <= y_pos + step_y;
                        end else begin
                            col   <= col + 3'd1;
                            x_pos <= x_pos + step_x;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cards_regfile.sv
// Randomized bench for cards_regfile: a slot/grid model built from the layout rules,
// checked every cycle, plus directed cases with hand-computed expectations.
`timescale 1ns/1ps
`ifndef CARDS_DEFS_SVH
`define CARDS_DEFS_SVH
`define CARD_MAX_NUM 18
`define CARD_MAX_NUM_SIZE 5
`define CARD_ADDRESS_SIZE 5
`define CARD_STATE_SIZE 2
`define CARD_DATA_SIZE 6
`define CARD_YX_POSITION_SIZE 24
`define CARD_NUM_EASY 8
`define CARD_NUM_NORMAL 12
`define CARD_NUM_HARD 18
`endif

module tb_cards_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [4:0]  num_of_cards_in;
    logic        clear_all;
    logic        wr_en;
    logic [4:0]  wr_address;
    logic [5:0]  wr_data;
    logic [4:0]  card_to_test_address;
    logic [1:0]  card_test_state;
    logic        regfile_sync;
    logic [5:0]  regfile_in;
    logic [23:0] yx_card_position;
    logic [4:0]  num_of_cards;
    logic        busy;
    logic        broadcast_done;

    cards_regfile dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .num_of_cards_in(num_of_cards_in),
        .clear_all(clear_all), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .card_to_test_address(card_to_test_address), .card_test_state(card_test_state),
        .regfile_sync(regfile_sync), .regfile_in(regfile_in), .yx_card_position(yx_card_position),
        .num_of_cards(num_of_cards), .busy(busy), .broadcast_done(broadcast_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    logic [5:0] mem_m [1:18];
    bit   m_active;
    int   m_k, m_nc;
    logic e_sync, e_busy, e_done;
    logic [5:0] e_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] grid_pos(input int k, input int nc);
        int cols, w, h, col, row, x, y;
        case (nc)
            8:  begin cols = 4; w = 200; h = 300; end
            12: begin cols = 4; w = 150; h = 200; end
            18: begin cols = 6; w = 100; h = 150; end
            default: begin cols = 6; w = 0; h = 0; end
        endcase
        col = (k - 1) % cols;
        row = (k - 1) / cols;
        x = 88 + col * (w + 16);
        y = 76 + row * (h + 16);
        return {y[11:0], x[11:0]};
    endfunction

    // Reference: what each output must be in the cycle after this edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 18; i++) mem_m[i] = '0;
            m_active = 0; m_k = 0; m_nc = 0;
            e_sync = 0; e_busy = 0; e_done = 0; e_in = '0;
        end else begin
            e_sync = 0; e_done = 0; e_in = '0;
            if (m_active && m_k < 18) begin
                m_k++;
                e_in = (m_k <= m_nc) ? mem_m[m_k] : '0;
            end else if (m_active) begin
                m_active = 0; e_busy = 0; e_done = 1;
            end else if (frame_start) begin
                m_active = 1; m_k = 1; m_nc = int'(num_of_cards_in);
                e_sync = 1; e_busy = 1;
                e_in = (m_nc >= 1) ? mem_m[1] : '0;
            end
            if (clear_all) begin
                for (int i = 1; i <= 18; i++) mem_m[i][5:4] = 2'b00;
            end else if (wr_en && wr_address >= 1 && wr_address <= 18) begin
                mem_m[int'(wr_address)] = wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sync", {31'b0, regfile_sync}, {31'b0, e_sync});
            chk("regfile_in", {26'b0, regfile_in}, {26'b0, e_in});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("done", {31'b0, broadcast_done}, {31'b0, e_done});
            chk("num_of_cards", {27'b0, num_of_cards}, 32'(m_nc));
            if (card_to_test_address >= 1 && card_to_test_address <= 18)
                chk("lookup", {30'b0, card_test_state}, {30'b0, mem_m[int'(card_to_test_address)][5:4]});
            else
                chk("lookup_oob", {30'b0, card_test_state}, 32'd0);
            if (e_busy)
                chk("yx", {8'b0, yx_card_position}, {8'b0, grid_pos(m_k, m_nc)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all();
        for (int a = 1; a <= 18; a++) begin
            wr_en = 1; wr_address = 5'(a);
            wr_data = {2'($urandom_range(1, 3)), 4'($urandom_range(1, 15))};
            step();
        end
        wr_en = 0;
    endtask

    initial begin
        rst = 1; frame_start = 0; num_of_cards_in = '0; clear_all = 0;
        wr_en = 0; wr_address = '0; wr_data = '0; card_to_test_address = '0;
        step();
        chk_en = 1;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("rst_yx", {8'b0, yx_card_position}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a <= 19; a++) begin
            step();
            card_to_test_address = 5'(a);
            @(negedge clk);
            chk("rst_lookup", {30'b0, card_test_state}, 32'd0);
        end

        step();
        wr_en = 1; wr_address = 5'd3; wr_data = {2'b01, 4'd5};
        step();
        wr_en = 0; card_to_test_address = 5'd3;
        @(negedge clk);
        chk("wr3_lookup", {30'b0, card_test_state}, 32'd1);
        step(); card_to_test_address = 5'd0;
        @(negedge clk);
        chk("addr0", {30'b0, card_test_state}, 32'd0);
        step(); card_to_test_address = 5'd19;
        @(negedge clk);
        chk("addr19", {30'b0, card_test_state}, 32'd0);

        // EASY, with an ignored restart and a difficulty change mid-stream
        step();
        fill_all();
        num_of_cards_in = 5'd8; frame_start = 1;
        step();
        for (int c = 1; c <= 19; c++) begin
            frame_start = (c == 4);
            if (c == 6) num_of_cards_in = 5'd18;
            @(negedge clk);
            if (c == 1) chk("easy_sync1", {31'b0, regfile_sync}, 32'd1);
            if (c == 2) begin
                chk("easy_sync2", {31'b0, regfile_sync}, 32'd0);
                chk("easy_yx2", {8'b0, yx_card_position}, {8'b0, 12'd76, 12'd304});
            end
            if (c == 5) chk("easy_yx5", {8'b0, yx_card_position}, {8'b0, 12'd392, 12'd88});
            if (c >= 9 && c <= 18) chk("easy_inactive", {26'b0, regfile_in}, 32'd0);
            if (c == 10) chk("easy_nc_held", {27'b0, num_of_cards}, 32'd8);
            if (c == 19) begin
                chk("easy_done", {31'b0, broadcast_done}, 32'd1);
                chk("easy_busy_end", {31'b0, busy}, 32'd0);
            end
            step();
        end
        frame_start = 0;

        // HARD, all entries written
        fill_all();
        num_of_cards_in = 5'd18; frame_start = 1;
        step();
        frame_start = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            chk("hard_busy", {31'b0, busy}, (c <= 18) ? 32'd1 : 32'd0);
            if (c == 7) chk("hard_yx7", {8'b0, yx_card_position}, {8'b0, 12'd242, 12'd88});
            if (c == 18) chk("hard_yx18", {8'b0, yx_card_position}, {8'b0, 12'd408, 12'd668});
            step();
        end

        // clear_all beats a simultaneous write
        clear_all = 1; wr_en = 1; wr_address = 5'd1; wr_data = 6'h3F;
        step();
        clear_all = 0; wr_en = 0;
        for (int a = 1; a <= 18; a++) begin
            card_to_test_address = 5'(a);
            @(negedge clk);
            chk("clear_state", {30'b0, card_test_state}, 32'd0);
            step();
        end

        // reset in the middle of a broadcast
        fill_all();
        num_of_cards_in = 5'd12; frame_start = 1;
        step();
        frame_start = 0;
        for (int c = 1; c <= 9; c++) step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_in", {26'b0, regfile_in}, 32'd0);
        chk("rst_mid_nc", {27'b0, num_of_cards}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            step();
            @(negedge clk);
            chk("rst_mid_nodone", {31'b0, broadcast_done}, 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 499) == 0);
            wr_en = ($urandom_range(0, 9) < 4);
            wr_address = 5'($urandom_range(0, 20));
            wr_data = 6'($urandom);
            clear_all = ($urandom_range(0, 63) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: num_of_cards_in = 5'd8;
                1: num_of_cards_in = 5'd12;
                2: num_of_cards_in = 5'd18;
                default: num_of_cards_in = 5'($urandom);
            endcase
            card_to_test_address = 5'($urandom_range(0, 20));
        end
        step();
        rst = 0; wr_en = 0; clear_all = 0; frame_start = 0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
